// File: rtl/dmem_mmio_pkg.sv
// Shared constants for dmem_mmio: MMIO word offsets (address[4:2]), STATUS bit positions,
// machine-timer compare reset value and the STATUS word packing helper.
package dmem_mmio_pkg;

  localparam logic [2:0] OFF_TXDATA      = 3'd0;
  localparam logic [2:0] OFF_STATUS      = 3'd1;
  localparam logic [2:0] OFF_MTIME_LO    = 3'd2;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd3;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd4;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd5;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic overflow, input logic [3:0] count);
    logic [31:0] w;
    w = 32'd0;
    w[ST_FULL]               = full;
    w[ST_EMPTY]              = empty;
    w[ST_OVERFLOW]           = overflow;
    w[ST_COUNT_LSB +: 4]     = count;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_fifo.sv
// sync_fifo: circular-buffer FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == CW'(0));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_buf[r_rd_ptr];
  assign count     = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_do_push) r_buf[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus MMIO window (TX FIFO, 64-bit machine timer) on the MEM-stage port.
// Optional feature macro DMEM_ACCESS_FAULT_EN adds the registered access_fault output.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h4000_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] address,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            timer_irq
`ifdef DMEM_ACCESS_FAULT_EN
  ,
  output logic            access_fault
`endif
);

  localparam int BYTE_SH = $clog2(XLEN / 8);
  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] RAM_LIMIT = XLEN'(DEPTH_WORDS * (XLEN / 8));
  localparam logic [XLEN-1:0] MMIO_LO   = XLEN'(MMIO_BASE);
  localparam logic [XLEN-1:0] MMIO_HI   = MMIO_LO + XLEN'(32'h20);

  logic [XLEN-1:0]  r_mem [DEPTH_WORDS];
  logic [63:0]      r_mtime;
  logic [63:0]      r_mtimecmp;
  logic             r_overflow;
  logic             r_timer_irq;

  logic             w_in_ram;
  logic             w_in_mmio;
  logic             w_mmio_ok;
  logic [IDX_W-1:0] w_ram_idx;
  logic [2:0]       w_off;
  logic             w_mmio_wr;
  logic             w_wr_tx;
  logic             w_wr_status;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_mmio_rd;
  logic [63:0]      w_mtime_nxt;
  logic [63:0]      w_mtimecmp_nxt;

  assign w_in_ram    = (address < RAM_LIMIT);
  assign w_in_mmio   = (address >= MMIO_LO) && (address < MMIO_HI);
  assign w_mmio_ok   = w_in_mmio && (address[1:0] == 2'b00);
  assign w_ram_idx   = address[BYTE_SH +: IDX_W];
  assign w_off       = address[4:2];
  assign w_mmio_wr   = mem_store && w_mmio_ok;
  assign w_wr_tx     = w_mmio_wr && (w_off == OFF_TXDATA);
  assign w_wr_status = w_mmio_wr && (w_off == OFF_STATUS);
  assign w_pop       = tx_valid && tx_ready;
  assign tx_valid    = !w_empty;
  assign timer_irq   = r_timer_irq;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_wr_tx),
    .pop   (w_pop),
    .din   (store_data[7:0]),
    .dout  (tx_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Whole-word RAM write; sub-word merging is done upstream.
  always_ff @(posedge clock) begin
    if (mem_store && w_in_ram) r_mem[w_ram_idx] <= store_data;
  end

  // Sticky overflow: set on a dropped push, cleared by writing STATUS with the overflow bit set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_wr_tx && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_wr_status && store_data[ST_OVERFLOW]) begin
      r_overflow <= 1'b0;
    end
  end

  // Timer next state; a MTIME_HI store lets the low half tick but drops its carry.
  always_comb begin
    w_mtime_nxt    = r_mtime + 64'd1;
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_mmio_wr && (w_off == OFF_MTIME_LO)) begin
      w_mtime_nxt = {r_mtime[63:32], store_data[31:0]};
    end else if (w_mmio_wr && (w_off == OFF_MTIME_HI)) begin
      w_mtime_nxt = {store_data[31:0], r_mtime[31:0] + 32'd1};
    end else begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
    if (w_mmio_wr && (w_off == OFF_MTIMECMP_LO)) begin
      w_mtimecmp_nxt = {r_mtimecmp[63:32], store_data[31:0]};
    end else if (w_mmio_wr && (w_off == OFF_MTIMECMP_HI)) begin
      w_mtimecmp_nxt = {store_data[31:0], r_mtimecmp[31:0]};
    end else begin
      w_mtimecmp_nxt = r_mtimecmp;
    end
  end

  // Irq compares next-state values so it tracks the registered mtime/mtimecmp exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mtime     <= 64'd0;
      r_mtimecmp  <= MTIMECMP_RESET;
      r_timer_irq <= 1'b0;
    end else begin
      r_mtime     <= w_mtime_nxt;
      r_mtimecmp  <= w_mtimecmp_nxt;
      r_timer_irq <= (w_mtime_nxt >= w_mtimecmp_nxt);
    end
  end

  // MMIO register read mux; reserved offsets read as zero.
  always_comb begin
    w_mmio_rd = 32'd0;
    case (w_off)
      OFF_TXDATA:      w_mmio_rd = 32'd0;
      OFF_STATUS:      w_mmio_rd = status_word(w_full, w_empty, r_overflow, 4'(w_count));
      OFF_MTIME_LO:    w_mmio_rd = r_mtime[31:0];
      OFF_MTIME_HI:    w_mmio_rd = r_mtime[63:32];
      OFF_MTIMECMP_LO: w_mmio_rd = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_mmio_rd = r_mtimecmp[63:32];
      default:         w_mmio_rd = 32'd0;
    endcase
  end

  // Same-cycle load path; returns the pre-edge value when a store hits the same word.
  always_comb begin
    load_data = '0;
    if (!mem_load) begin
      load_data = '0;
    end else if (w_in_ram) begin
      load_data = r_mem[w_ram_idx];
    end else if (w_mmio_ok) begin
      load_data = XLEN'(w_mmio_rd);
    end else begin
      load_data = '0;
    end
  end

`ifdef DMEM_ACCESS_FAULT_EN
  logic r_access_fault;
  assign access_fault = r_access_fault;

  // One-cycle fault pulse for unmapped or misaligned-MMIO accesses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_access_fault <= 1'b0;
    end else begin
      r_access_fault <= (mem_load || mem_store) &&
                        ((!w_in_ram && !w_in_mmio) || (w_in_mmio && (address[1:0] != 2'b00)));
    end
  end
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed table, hand-written FIFO/timer/reset
// sequences and randomized traffic against a queue/array reference model.
module tb_dmem_mmio;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = 32'd0;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] load_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;
`ifdef DMEM_ACCESS_FAULT_EN
  logic        access_fault;
`endif

  int checks = 0;
  int errors = 0;

  dmem_mmio dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .store_data (store_data),
    .load_data  (load_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .timer_irq  (timer_irq)
`ifdef DMEM_ACCESS_FAULT_EN
    ,
    .access_fault (access_fault)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Reference model state
  logic [31:0] m_mem [int];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  bit          m_irq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h20) && (a[1:0] == 2'b00);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_mtime = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_irq   = 1'b0;
  endtask

  // Returns 1 when the expected load value is known (unwritten RAM is undefined).
  function automatic bit model_load(input logic ld, input logic [31:0] a, output logic [31:0] v);
    int n;
    v = 32'd0;
    n = m_q.size();
    if (!ld) return 1'b1;
    if (a < 32'd4096) begin
      if (!m_mem.exists(int'(a >> 2))) return 1'b0;
      v = m_mem[int'(a >> 2)];
      return 1'b1;
    end
    if (is_mmio(a)) begin
      case (a - BASE)
        32'h04: v = 32'(n) * 32'd16 + (m_ovf ? 32'd4 : 32'd0) +
                    ((n == 0) ? 32'd2 : 32'd0) + ((n == 8) ? 32'd1 : 32'd0);
        32'h08: v = m_mtime[31:0];
        32'h0C: v = m_mtime[63:32];
        32'h10: v = m_cmp[31:0];
        32'h14: v = m_cmp[63:32];
        default: v = 32'd0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [63:0] nt;
    logic [63:0] nc;
    bit pop;
    bit push;
    bit full;
    nt   = m_mtime + 64'd1;
    nc   = m_cmp;
    pop  = (m_q.size() != 0) && tx_ready;
    push = 1'b0;
    full = (m_q.size() == 8);
    if (mem_store && address < 32'd4096) m_mem[int'(address >> 2)] = store_data;
    if (mem_store && is_mmio(address)) begin
      case (address - BASE)
        32'h00: push = 1'b1;
        32'h04: if (store_data[2]) m_ovf = 1'b0;
        32'h08: nt = {m_mtime[63:32], store_data};
        32'h0C: nt = {store_data, m_mtime[31:0] + 32'd1};
        32'h10: nc[31:0] = store_data;
        32'h14: nc[63:32] = store_data;
        default: ;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) m_q.push_back(store_data[7:0]);
      else m_ovf = 1'b1;
    end
    m_mtime = nt;
    m_cmp   = nc;
    m_irq   = (nt >= nc);
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] v;
    if (model_load(mem_load, address, v)) chk({tag, ":load_data"}, 64'(load_data), 64'(v));
    chk({tag, ":tx_valid"}, 64'(tx_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, ":tx_data"}, 64'(tx_data), 64'(m_q[0]));
    chk({tag, ":timer_irq"}, 64'(timer_irq), 64'(m_irq));
  endtask

  task automatic step(input string tag);
    #2;
    check_outputs(tag);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
    mem_load = ld; mem_store = st; address = a; store_data = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    drive(1'b0, 1'b1, a, d);
    step(tag);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd_expect(input logic [31:0] a, input logic [31:0] exp, input string tag);
    drive(1'b1, 1'b0, a, 32'd0);
    #1;
    chk(tag, 64'(load_data), 64'(exp));
    step(tag);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];
  logic [7:0] drain_exp [8];
  int first_irq;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h10,          32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,          32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h12,          32'h0,         32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h8000_0000,   32'h0,         32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h10,          32'h0,         32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h10,          32'h1234_5678, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b1, 1'b0, 32'h13,          32'h0,         32'h1234_5678};
    tbl[7]  = '{1'b1, 1'b0, BASE + 32'h1,    32'h0,         32'h0};
    tbl[8]  = '{1'b1, 1'b0, BASE + 32'h4,    32'h0,         32'h2};
    tbl[9]  = '{1'b1, 1'b0, BASE + 32'h10,   32'h0,         32'hFFFF_FFFF};
    tbl[10] = '{1'b1, 1'b0, BASE + 32'h18,   32'h0,         32'h0};

    // Reset state
    model_reset();
    repeat (3) @(posedge clock);
    #3;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_timer_irq", 64'(timer_irq), 64'd0);
    drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    #1 chk("rst_status", 64'(load_data), 64'h2);
    drive(1'b1, 1'b0, BASE + 32'h14, 32'd0);
    #1 chk("rst_mtimecmp_hi", 64'(load_data), 64'hFFFF_FFFF);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    model_edge();
    #1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].ld, tbl[i].st, tbl[i].a, tbl[i].d);
      #1 chk($sformatf("table%0d", i), 64'(load_data), 64'(tbl[i].exp));
      step($sformatf("table%0d_model", i));
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    // FIFO ordering and drain
    tx_ready = 1'b0;
    wr(BASE, 32'h41, "push41");
    wr(BASE, 32'h42, "push42");
    wr(BASE, 32'h43, "push43");
    chk("tx_head", 64'(tx_data), 64'h41);
    chk("tx_valid3", 64'(tx_valid), 64'd1);
    rd_expect(BASE + 32'h4, 32'h30, "status_cnt3");
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("drain%0d", i), 64'(tx_data), 64'(32'h41 + i));
      step("drain");
    end
    tx_ready = 1'b0;
    chk("drained_valid", 64'(tx_valid), 64'd0);
    rd_expect(BASE + 32'h4, 32'h2, "status_empty");

    // Overflow and clear
    for (int i = 0; i < 9; i++) wr(BASE, 32'h10 + i, "push_ovf");
    rd_expect(BASE + 32'h4, 32'h85, "status_full_ovf");
    wr(BASE + 32'h4, 32'h4, "clear_ovf");
    rd_expect(BASE + 32'h4, 32'h81, "status_ovf_cleared");

    // Push while full with simultaneous pop
    tx_ready = 1'b1;
    drive(1'b0, 1'b1, BASE, 32'hAA);
    #1 chk("full_pushpop_head", 64'(tx_data), 64'h10);
    step("full_pushpop");
    tx_ready = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    rd_expect(BASE + 32'h4, 32'h81, "status_after_pushpop");
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'(8'h11 + i);
    drain_exp[7] = 8'hAA;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("pushpop_drain%0d", i), 64'(tx_data), 64'(drain_exp[i]));
      step("pushpop_drain");
    end
    tx_ready = 1'b0;
    chk("pushpop_empty", 64'(tx_valid), 64'd0);

    // Timer compare
    wr(BASE + 32'h14, 32'd0, "cmp_hi");
    wr(BASE + 32'h10, 32'd20, "cmp_lo");
    wr(BASE + 32'h08, 32'd0, "mtime_lo");
    chk("irq_after_mtime_clear", 64'(timer_irq), 64'd0);
    first_irq = -1;
    for (int k = 1; k <= 25; k++) begin
      step("timer_wait");
      if (timer_irq && first_irq < 0) first_irq = k;
    end
    chk("irq_rise_cycle", 64'(first_irq), 64'd20);
    chk("irq_held", 64'(timer_irq), 64'd1);
    wr(BASE + 32'h10, 32'hFFFF_FFFF, "cmp_lo_max");
    chk("irq_fall", 64'(timer_irq), 64'd0);
    wr(BASE + 32'h0C, 32'h5, "mtime_hi");
    rd_expect(BASE + 32'h0C, 32'h5, "mtime_hi_read");

    // Reset in the middle of a drain
    for (int i = 0; i < 6; i++) wr(BASE, 32'h60 + i, "push_prereset");
    tx_ready = 1'b1;
    step("predrain");
    #2;
    reset = 1'b0;
    #1;
    chk("async_tx_valid", 64'(tx_valid), 64'd0);
    drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    #0.5 chk("async_status", 64'(load_data), 64'h2);
    drive(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    #0.5 chk("async_mtime", 64'(load_data), 64'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tx_ready = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    model_edge();
    #1;
    drive(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    #1 chk("mtime_small", 64'(load_data < 32'd8), 64'd1);
    step("mtime_after_reset");
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, "ram_fill");
    for (int n = 0; n < 800; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 4)      a = 32'($urandom_range(0, 63));
      else if (r < 8) a = BASE + 32'($urandom_range(0, 31));
      else if (r < 9) a = BASE + 32'h20 + 32'($urandom_range(0, 3));
      else            a = 32'h8000_0000 | 32'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      step("rand");
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tx_ready = 1'b0;
    step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem on the CPU's MEM-stage port: consumes address, mem_load, mem_store and store_data, and returns load_data in the same cycle.
- Contains a word-addressed data RAM (asynchronous read, synchronous write) and a small MMIO region.
- The MMIO region holds a UART-style transmit FIFO with a valid/ready drain port, plus a 64-bit machine timer (mtime/mtimecmp) that drives a timer interrupt line.

Parameters:
- XLEN, 32, data/address width (32 or 64).
- DEPTH_WORDS, 1024, RAM depth in XLEN-bit words (power of two).
- MMIO_BASE, 32'h4000_0000, base address of the MMIO window (window size 0x20).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, ≥2).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  XLEN  byte address from the MEM stage.
- mem_load  input  1  load request this cycle.
- mem_store  input  1  store request this cycle; store_data is the already-merged full word.
- store_data  input  XLEN  word to write.
- load_data  output  XLEN  combinational read word.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  sink accepts head byte.
- timer_irq  output  1  registered; high while mtime ≥ mtimecmp (unsigned).

Behaviour:
- Decode:
  - RAM region: address < DEPTH_WORDS*XLEN/8. Index = address >> log2(XLEN/8); low bits are ignored, and the whole word is written.
  - MMIO region: MMIO_BASE ≤ address < MMIO_BASE+0x20; offset = address[4:2].
  - Anything else is unmapped.
- load_data is combinational from address:
  - RAM word, or the MMIO register zero-extended to XLEN, or 0 when unmapped.
  - Returns 0 whenever mem_load=0.
  - Loads have no side effects.
- Stores take effect at the rising edge when mem_store=1. Unmapped stores are ignored.
- MMIO map (32-bit registers):
  - 0x00 TXDATA: write pushes store_data[7:0]; reads 0.
  - 0x04 STATUS:
    - bit0 full, bit1 empty, bit2 overflow (sticky), bits[7:4] count.
    - Writing with bit2=1 clears overflow.
  - 0x08 MTIME_LO.
  - 0x0C MTIME_HI.
  - 0x10 MTIMECMP_LO.
  - 0x14 MTIMECMP_HI.
- TX FIFO:
  - Circular buffer with wr_ptr/rd_ptr and a count of log2(FIFO_DEPTH)+1 bits.
  - Pop when tx_valid && tx_ready.
  - Push accepted if !full, or if a pop occurs in the same cycle (full with simultaneous push+pop: count unchanged, both pointers advance).
  - Push while full without a pop: byte dropped, overflow set.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data/tx_valid are valid in the cycle after the push edge.
- Timer:
  - mtime increments by 1 every cycle, wrapping at 2^64.
  - Store to MTIME_LO: lo ← data, hi unchanged, no increment that cycle.
  - Store to MTIME_HI: hi ← data, lo increments normally (carry discarded that cycle).
  - mtimecmp updates only on stores.
  - timer_irq is registered from the next-state comparison, so it is high the cycle mtime first equals mtimecmp.
- Reset (async assert, sync-release expected):
  - FIFO empty, pointers 0, overflow 0.
  - mtime 0, mtimecmp all-ones, timer_irq 0, tx_valid 0.
  - RAM contents undefined.
  - Reset mid-transfer discards the FIFO contents.
- Simultaneous mem_load and mem_store: the load returns the old value; the store commits at the edge.

Optional Feature:
- DMEM_ACCESS_FAULT_EN: adds output access_fault (1 bit, registered, reset 0).
  - Pulses high one cycle after any load/store to an unmapped address, or to a misaligned MMIO address (address[1:0]≠0).
- Without the macro the port is absent and such accesses are silently ignored (load returns 0).

Decomposition:
- Shared package holds:
  - MMIO offset constants (OFF_TXDATA, OFF_STATUS, OFF_MTIME_LO/HI, OFF_MTIMECMP_LO/HI).
  - STATUS bit indices.
  - MTIMECMP reset value.
- One sub-module, sync_fifo: parameter WIDTH/DEPTH; ports push, pop, din, dout, full, empty, count.
- Decode, RAM and timer stay in dmem_mmio.

Test Plan:
- Store 32'hDEADBEEF to 0x10, load 0x10 → load_data=32'hDEADBEEF; load 0x12 → same word; load unmapped 0x8000_0000 → 0.
- tx_ready=0; store 0x41, 0x42, 0x43 to TXDATA → STATUS count=3, tx_data=0x41, tx_valid=1; raise tx_ready 3 cycles → bytes drained 0x41, 0x42, 0x43 in order, empty=1.
- tx_ready=0; push 9 bytes with FIFO_DEPTH=8 → full=1, overflow=1, 9th byte absent; write STATUS with 0x4 → overflow=0.
- Full FIFO, tx_ready=1 plus a push in the same cycle → count stays 8, new byte appears after 8 pops.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20, MTIME_LO=0 → timer_irq rises exactly 20 cycles later; write MTIMECMP_LO=32'hFFFF_FFFF → irq falls next cycle.
- Assert reset mid-drain with count=5 → tx_valid=0, count=0, mtime=0 immediately (async); the first load of MTIME_LO after release is small.
